muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised multi-cycle RV32M/RV64M execution unit that runs beside the integer ALU in the execute stage. It implements all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) behind valid/ready handshakes. Multiplies take 2 cycles; divides use an iterative restoring algorithm of DATA_WIDTH steps. The hazard unit stalls on Busy_o and discards in-flight ops with Kill_i.

Parameters:
DATA_WIDTH, 32, operand/result width (32 or 64; must be even, ≥8)
CNT_WIDTH, $clog2(DATA_WIDTH)+1, divide step counter width (derived, do not override)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
Valid_i  input  1  request valid
Ready_o  output  1  unit can accept request (IDLE only)
Op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA_i  input  DATA_WIDTH  rs1 operand (multiplicand / dividend)
SrcB_i  input  DATA_WIDTH  rs2 operand (multiplier / divisor)
Kill_i  input  1  abort current op (pipeline flush)
Valid_o  output  1  result valid
Ready_i  input  1  consumer accepts result
Result_o  output  DATA_WIDTH  result, stable while Valid_o=1
Busy_o  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE; Ready_o=1, Valid_o=0, Busy_o=0, Result_o=0; step counter and internal registers cleared. Reset dominates every other input, mid-operation included.
- Accept: at the edge where Valid_i&&Ready_o, latch Op_i, SrcA_i, SrcB_i. Operands are not sampled again afterwards.
- States: IDLE, MUL, DIV, DONE.
- IDLE -> MUL when a multiply op is accepted.
- IDLE -> DIV when a divide op is accepted with SrcB≠0 and not signed overflow.
- IDLE -> DONE directly for the divide special cases below.
- MUL: computes the 2*DATA_WIDTH product in one cycle. Sign rules: MUL and MULH are signed×signed; MULHSU is signed×unsigned; MULHU is unsigned×unsigned. MUL returns the low half; MULH* return the high half. Registered into Result_o, then -> DONE.
- Multiply latency: accept edge T, Valid_o=1 from T+2.
- DIV, signed ops (DIV/REM): operate on magnitudes; quotient is negated if signA≠signB; remainder takes the dividend's sign.
- DIV, unsigned ops (DIVU/REMU): operands used as-is.
- DIV iteration: one restoring step per cycle for exactly DATA_WIDTH cycles; counter counts DATA_WIDTH-1 down to 0.
- DIV exit: on the final step, apply sign correction, select quotient (DIV/DIVU) or remainder (REM/REMU) into Result_o, then -> DONE.
- Divide latency: Valid_o=1 at T+DATA_WIDTH+1.
- Divide by zero (SrcB=0): quotient = all ones; remainder = SrcA. Valid_o at T+1.
- Signed overflow (DIV/REM, SrcA = most-negative, SrcB = -1): quotient = SrcA; remainder = 0. Valid_o at T+1.
- DONE: Valid_o=1 and Result_o held until Valid_o&&Ready_i at an edge, then -> IDLE. Ready_o=1 from the next cycle. No back-to-back accept in the same cycle as result handoff.
- Kill_i=1 at an edge in MUL, DIV or DONE -> IDLE. Valid_o=0 next cycle; result discarded.
- Kill_i in IDLE suppresses acceptance: Valid_i is ignored that cycle.
- Kill_i and rst_i together: reset behaviour applies.
- Ready_o = (state==IDLE). Busy_o = !Ready_o.
- Result_o retains its last value in IDLE; it is not cleared except by reset.
- No combinational path from Valid_i, Op_i or Src*_i to any output.

Test Plan:
- Reset mid-DIV: assert rst_i 5 cycles after accepting DIVU 100/7 -> next cycle Ready_o=1, Valid_o=0, Result_o=0; a following MUL 3*4 returns 12.
- Multiply signs (W=32): MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULHU same operands -> 0xFFFFFFFE; MUL -> 0x00000001. Each valid exactly 2 cycles after accept.
- Signed divide: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF. Valid at T+33.
- Special cases: DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both at T+1; DIV 0x80000000/-1 -> 0x80000000 and REM same operands -> 0.
- Backpressure and kill: hold Ready_i=0 for 10 cycles after MULHU completes -> Valid_o and Result_o stable throughout, Ready_o=0. Then Kill_i at step 10 of a DIV -> idle next cycle, no Valid_o pulse.
- Parameter sweep at DATA_WIDTH=64: DIV -(2^63) by 3 -> 0xD555555555555556; MULHU (2^64-1)² -> 0xFFFFFFFFFFFFFFFE. Divide valid at T+65.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: 2-cycle multiply, DATA_WIDTH-step restoring divide,
// valid/ready on both sides, kill to discard in-flight work.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Valid_i,
  output logic                  Ready_o,
  input  logic [2:0]            Op_i,
  input  logic [DATA_WIDTH-1:0] SrcA_i,
  input  logic [DATA_WIDTH-1:0] SrcB_i,
  input  logic                  Kill_i,
  output logic                  Valid_o,
  input  logic                  Ready_i,
  output logic [DATA_WIDTH-1:0] Result_o,
  output logic                  Busy_o
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                r_state, w_state_next;
  logic [2:0]            r_op;
  logic [DATA_WIDTH-1:0] r_a, r_b;
  logic [DATA_WIDTH-1:0] r_quo, r_rem, r_divisor;
  logic                  r_neg_q, r_neg_r;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_result;

  // Request decode (only used on the accept edge)
  logic                  w_accept, w_is_div, w_signed_div, w_b_zero, w_ovf, w_special;
  logic                  w_a_neg, w_b_neg;
  logic [DATA_WIDTH-1:0] w_special_res, w_a_mag, w_b_mag;

  assign w_accept     = Valid_i && (r_state == S_IDLE) && !Kill_i;
  assign w_is_div     = Op_i[2];
  assign w_signed_div = !Op_i[0];
  assign w_b_zero     = (SrcB_i == '0);
  assign w_ovf        = w_signed_div && (SrcA_i == MOST_NEG) && (SrcB_i == '1);
  assign w_special    = w_is_div && (w_b_zero || w_ovf);
  assign w_a_neg      = w_signed_div && SrcA_i[DATA_WIDTH-1];
  assign w_b_neg      = w_signed_div && SrcB_i[DATA_WIDTH-1];
  assign w_a_mag      = w_a_neg ? -SrcA_i : SrcA_i;
  assign w_b_mag      = w_b_neg ? -SrcB_i : SrcB_i;

  always_comb begin
    w_special_res = '0;
    if (w_b_zero) w_special_res = Op_i[1] ? SrcA_i : '1;
    else          w_special_res = Op_i[1] ? '0 : SrcA_i;
  end

  // Multiply: each operand extended by one bit so one signed multiplier covers all sign mixes
  logic                         w_ma_signed, w_mb_signed;
  logic signed [DATA_WIDTH:0]   w_ma, w_mb;
  logic [2*DATA_WIDTH-1:0]      w_prod;
  logic [DATA_WIDTH-1:0]        w_mul_res;

  assign w_ma_signed = (r_op[1:0] != 2'b11);
  assign w_mb_signed = !r_op[1];
  assign w_ma        = $signed({w_ma_signed & r_a[DATA_WIDTH-1], r_a});
  assign w_mb        = $signed({w_mb_signed & r_b[DATA_WIDTH-1], r_b});
  assign w_prod      = (2*DATA_WIDTH)'(w_ma) * (2*DATA_WIDTH)'(w_mb);
  assign w_mul_res   = (r_op == 3'b000) ? w_prod[DATA_WIDTH-1:0] : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];

  // Restoring divide step: r_quo shifts the dividend out as quotient bits shift in
  logic [DATA_WIDTH:0]   w_shift, w_diff;
  logic [DATA_WIDTH-1:0] w_rem_next, w_quo_next, w_div_res;

  assign w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_rem_next = w_diff[DATA_WIDTH] ? w_shift[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
  assign w_quo_next = {r_quo[DATA_WIDTH-2:0], !w_diff[DATA_WIDTH]};
  assign w_div_res  = r_op[1] ? (r_neg_r ? -w_rem_next : w_rem_next)
                              : (r_neg_q ? -w_quo_next : w_quo_next);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (!w_is_div)      w_state_next = S_MUL;
        else if (w_special) w_state_next = S_DONE;
        else                w_state_next = S_DIV;
      end
      S_MUL:  w_state_next = S_DONE;
      S_DIV:  if (r_cnt == '0) w_state_next = S_DONE;
      S_DONE: if (Ready_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (Kill_i && r_state != S_IDLE) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op <= Op_i;
          if (!w_is_div) begin
            r_a <= SrcA_i;
            r_b <= SrcB_i;
          end else if (w_special) begin
            r_result <= w_special_res;
          end else begin
            r_quo     <= w_a_mag;
            r_rem     <= '0;
            r_divisor <= w_b_mag;
            r_neg_q   <= w_a_neg ^ w_b_neg;
            r_neg_r   <= w_a_neg;
            r_cnt     <= CNT_LAST;
          end
        end
        S_MUL: if (!Kill_i) r_result <= w_mul_res;
        S_DIV: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0 && !Kill_i) r_result <= w_div_res;
        end
        default: ;
      endcase
    end
  end

  assign Ready_o  = (r_state == S_IDLE);
  assign Busy_o   = !Ready_o;
  assign Valid_o  = (r_state == S_DONE);
  assign Result_o = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at DATA_WIDTH=32 and 64.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  logic        v32 = 0, k32 = 0, r32 = 0;
  logic [2:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        rdy32, vo32, busy32;
  logic [31:0] res32;

  logic        v64 = 0, k64 = 0, r64 = 0;
  logic [2:0]  op64 = '0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        rdy64, vo64, busy64;
  logic [63:0] res64;

  muldiv_unit #(.DATA_WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .Valid_i(v32), .Ready_o(rdy32), .Op_i(op32),
    .SrcA_i(a32), .SrcB_i(b32), .Kill_i(k32), .Valid_o(vo32), .Ready_i(r32),
    .Result_o(res32), .Busy_o(busy32)
  );

  muldiv_unit #(.DATA_WIDTH(64)) dut64 (
    .clk_i(clk), .rst_i(rst), .Valid_i(v64), .Ready_o(rdy64), .Op_i(op64),
    .SrcA_i(a64), .SrcB_i(b64), .Kill_i(k64), .Valid_o(vo64), .Ready_i(r64),
    .Result_o(res64), .Busy_o(busy64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    v32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk);
    #1 v32 = 1'b0; a32 = '0; b32 = '0;
  endtask

  // cnt = edges after the accept edge before Valid_o is seen
  task automatic wait32(input string tag, input logic [31:0] exp_res, input int exp_cnt);
    int cnt = 0;
    @(negedge clk);
    while (!vo32 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'(exp_cnt));
    check({tag, "_res"}, 64'(res32), 64'(exp_res));
  endtask

  task automatic take32(input string tag);
    @(negedge clk);
    r32 = 1'b1;
    @(posedge clk);
    #1 r32 = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, rdy32, vo32}, 64'b10);
  endtask

  task automatic run32(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_cnt);
    issue32(op, a, b);
    wait32(tag, exp_res, exp_cnt);
    take32(tag);
  endtask

  task automatic run64(input string tag, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_res, input int exp_cnt);
    int cnt = 0;
    @(negedge clk);
    v64 = 1'b1; op64 = op; a64 = a; b64 = b;
    @(posedge clk);
    #1 v64 = 1'b0; a64 = '0; b64 = '0;
    @(negedge clk);
    while (!vo64 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'(exp_cnt));
    check({tag, "_res"}, res64, exp_res);
    @(negedge clk);
    r64 = 1'b1;
    @(posedge clk);
    #1 r64 = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {62'd0, rdy64, vo64}, 64'b10);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst32_flags", {61'd0, rdy32, vo32, busy32}, 64'b100);
    check("rst32_res", 64'(res32), 64'd0);
    check("rst64_flags", {61'd0, rdy64, vo64, busy64}, 64'b100);
    check("rst64_res", res64, 64'd0);

    // reset five cycles into DIVU 100/7
    issue32(3'b101, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstdiv_flags", {61'd0, rdy32, vo32, busy32}, 64'b100);
    check("rstdiv_res", 64'(res32), 64'd0);
    run32("mul_3x4", 3'b000, 32'd3, 32'd4, 32'd12, 1);

    // multiply sign handling
    run32("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
    run32("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run32("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
    run32("mul_lo", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    run32("mul_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1);

    // divides
    run32("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
    run32("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
    run32("divu_big", 3'b101, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32);
    run32("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 32);
    run32("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32);
    run32("divu_noovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32);

    // special cases
    run32("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run32("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 0);
    run32("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run32("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);

    // backpressure: result held while Ready_i stays low
    issue32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait32("bp_mulhu", 32'hFFFF_FFFE, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {rdy32, vo32, busy32, res32}, {3'b011, 32'hFFFF_FFFE});
    end
    take32("bp");

    // kill on the tenth divide step
    issue32(3'b100, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 k32 = 1'b1;
    @(posedge clk);
    #1 k32 = 1'b0;
    @(negedge clk);
    check("kill_flags", {61'd0, rdy32, vo32, busy32}, 64'b100);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vo32) seen = 1'b1;
    end
    check("kill_nopulse", 64'(seen), 64'd0);
    check("kill_res_kept", 64'(res32), 64'hFFFF_FFFE);

    // kill in IDLE suppresses acceptance
    @(negedge clk);
    v32 = 1'b1; k32 = 1'b1; op32 = 3'b000; a32 = 32'd2; b32 = 32'd2;
    @(posedge clk);
    #1 v32 = 1'b0; k32 = 1'b0;
    @(negedge clk);
    check("kill_idle", {61'd0, rdy32, vo32, busy32}, 64'b100);
    repeat (3) @(negedge clk);
    check("kill_idle_stay", {61'd0, rdy32, vo32, busy32}, 64'b100);

    // 64-bit instance
    run64("div64", 3'b100, 64'h8000_0000_0000_0000, 64'd3, 64'hD555_5555_5555_5556, 64);
    run64("mulhu64", 3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 1);
    run64("rem64", 3'b110, 64'h8000_0000_0000_0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
